prod_accum: RTL and testbench
=============================

PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 6, multiplier operand width; product width is 2*WIDTH.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, accumulator width; legal range ACC_WIDTH >= 2*WIDTH.
REQ-003 SHALL have parameter COUNT, default 4, products per block; legal range COUNT >= 1.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clear  input  1  synchronous abort of the current block.
REQ-007 SHALL have port in_valid  input  1  product present.
REQ-008 SHALL have port in_ready  output  1  block accepts a product.
REQ-009 SHALL have port product  input  2*WIDTH  two's-complement product from the upstream multiplier.
REQ-010 SHALL have port out_valid  output  1  block sum present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the sum.
REQ-012 SHALL have port out_sum  output  ACC_WIDTH  two's-complement block sum.
REQ-013 SHALL have port out_ovf  output  1  overflow occurred in the presented block.

Function
REQ-014 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL transfer a product on a rising edge where in_valid=1 and in_ready=1; product sign-extended to ACC_WIDTH and added to acc.
REQ-016 SHALL count transfers in cnt (width clog2(COUNT)+1), 0..COUNT-1.
REQ-017 SHALL, on the transfer with cnt=COUNT-1, load the final sum into out_sum, enter HOLD, and reset cnt to 0; out_valid rises in the next cycle (latency 1 cycle after the COUNT-th transfer).
REQ-018 SHALL, with COUNT=1, enter HOLD after every transfer.
REQ-019 SHALL hold out_sum and out_ovf stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, in HOLD with out_ready=1, return to ACCUM with acc=0 and ovf=0; in_ready=1 from the next cycle, no same-cycle pass-through.
REQ-021 SHALL set sticky ovf when the signed add result lies outside ACC_WIDTH range; ovf is cleared only at block start, clear, or reset.
REQ-022 SHALL give clear priority over all handshakes: acc=0, cnt=0, ovf=0, state ACCUM; a held sum is discarded, and a product presented in the same cycle is dropped.
REQ-023 SHALL ignore in_valid while in HOLD and ignore out_ready while in ACCUM.

Reset
REQ-024 SHALL, when rst_n=0 at a rising edge, set state ACCUM, acc=0, cnt=0, out_sum=0, out_ovf=0, out_valid=0, in_ready=1 from the next cycle.
REQ-025 SHALL, on reset mid-block or during HOLD, discard all partial and held results.

Configuration
REQ-026 SHALL honour macro PROD_ACCUM_SAT_EN: when defined, overflowing adds clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), and later adds continue from the clamped value.
REQ-027 SHALL, without PROD_ACCUM_SAT_EN, wrap modulo 2^ACC_WIDTH; ovf reporting is identical in both builds.

Structure
REQ-028 SHALL place the state enum (ACCUM, HOLD) and the default WIDTH/ACC_WIDTH/COUNT constants in package prod_accum_pkg.
REQ-029 SHALL implement the signed add, overflow detect and optional clamp in one combinational sub-module prod_accum_add.

Verification
REQ-030 SHALL cover the basic block: defaults, products 10, -15 (12'hFF1), 20, 1 back-to-back -> out_valid one cycle after the 4th transfer, out_sum=16'd16, out_ovf=0.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles -> in_ready=0, out_sum stable; out_ready=1 -> in_ready=1 the next cycle, next block starts from 0.
REQ-032 SHALL cover saturation: ACC_WIDTH=12, products 1024, 1024 -> with macro out_sum=12'h7FF, out_ovf=1; without macro out_sum=12'h800, out_ovf=1.
REQ-033 SHALL cover clear: clear after 2 transfers of 7 -> next block of 4x(-1) yields out_sum=-4 (16'hFFFC).
REQ-034 SHALL cover reset: rst_n=0 for 1 cycle while in HOLD -> out_valid=0, out_sum=0, in_ready=1 afterwards.
REQ-035 SHALL cover COUNT=1: product -1024 -> out_sum=16'hFC00 with out_valid one cycle later.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared types and default sizing for the product accumulator.
// Holds the two-state handshake enum and default WIDTH/ACC_WIDTH/COUNT.
// No logic; imported by prod_accum and prod_accum_add.
package prod_accum_pkg;

   localparam int DEF_WIDTH     = 6;
   localparam int DEF_ACC_WIDTH = 16;
   localparam int DEF_COUNT     = 4;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

endpackage

// File: rtl/prod_accum_add.sv
// Signed add of a sign-extended product into the accumulator, with overflow flag.
// Latency: purely combinational. Backpressure: none (no handshake).
// Build option PROD_ACCUM_SAT_EN: clamp to the signed extremes on overflow instead of wrapping.
module prod_accum_add
   import prod_accum_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0]   product,
   output logic [ACC_WIDTH-1:0] sum,
   output logic                 ovf
);

   logic [ACC_WIDTH:0] acc_x;
   logic [ACC_WIDTH:0] prod_x;
   logic [ACC_WIDTH:0] raw;

   // One guard bit above the accumulator: overflow when guard and sign disagree.
   always_comb begin
      acc_x  = {acc[ACC_WIDTH-1], acc};
      prod_x = {{(ACC_WIDTH+1-2*WIDTH){product[2*WIDTH-1]}}, product};
      raw    = acc_x + prod_x;
      ovf    = raw[ACC_WIDTH] ^ raw[ACC_WIDTH-1];
`ifdef PROD_ACCUM_SAT_EN
      // Guard bit carries the true sign, so it selects which extreme to clamp to.
      if (ovf)
         sum = raw[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      else
         sum = raw[ACC_WIDTH-1:0];
`else
      sum = raw[ACC_WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/prod_accum.sv
// Sums blocks of COUNT signed products and presents each block sum with a sticky overflow flag.
// Latency: out_valid one cycle after the COUNT-th transfer. Backpressure: in_ready low while a sum is held.
// Build option PROD_ACCUM_SAT_EN selects saturating instead of wrapping accumulation.
module prod_accum
   import prod_accum_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int COUNT     = DEF_COUNT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   product,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic                 out_ovf
);

   localparam int CNT_W = $clog2(COUNT) + 1;

   state_t               state;
   state_t               state_nxt;
   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_W-1:0]     cnt;
   logic                 ovf;
   logic [ACC_WIDTH-1:0] add_sum;
   logic                 add_ovf;
   logic                 xfer_in;
   logic                 xfer_out;
   logic                 last;

   prod_accum_add #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_add (
      .acc     (acc),
      .product (product),
      .sum     (add_sum),
      .ovf     (add_ovf)
   );

   assign xfer_in  = in_valid && (state == ACCUM);
   assign xfer_out = out_ready && (state == HOLD);
   assign last     = (cnt == CNT_W'(COUNT - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ACCUM;
      else
         state <= state_nxt;
   end

   // Next state: clear wins over both handshakes.
   always_comb begin
      state_nxt = state;
      if (clear)
         state_nxt = ACCUM;
      else begin
         case (state)
            ACCUM:   if (xfer_in && last) state_nxt = HOLD;
            HOLD:    if (out_ready)       state_nxt = ACCUM;
            default: state_nxt = ACCUM;
         endcase
      end
   end

   // Handshake outputs decode directly from state.
   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == HOLD);
   end

   // Datapath: accumulate, capture the block result, restart from zero after hand-off.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         out_sum <= '0;
         out_ovf <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (xfer_in) begin
         acc <= add_sum;
         ovf <= ovf | add_ovf;
         if (last) begin
            out_sum <= add_sum;
            out_ovf <= ovf | add_ovf;
            cnt     <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else if (xfer_out) begin
         acc <= '0;
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: three instances (defaults, ACC_WIDTH=12/COUNT=2, COUNT=1).
// Expected block results are queued at stimulus time and checked by a separate monitor.
// Directed cycle checks cover reset, latency, backpressure, clear and reset-in-hold.
module tb_prod_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Instance 0: default parameters
   logic        rst0 = 1'b0, clr0 = 1'b0, iv0 = 1'b0, or0 = 1'b1;
   logic [11:0] p0 = '0;
   logic        ir0, ov0, ovf0;
   logic [15:0] sum0;

   // Instance 1: ACC_WIDTH=12, COUNT=2
   logic        rst1 = 1'b0, clr1 = 1'b0, iv1 = 1'b0, or1 = 1'b1;
   logic [11:0] p1 = '0;
   logic        ir1, ov1, ovf1;
   logic [11:0] sum1;

   // Instance 2: COUNT=1
   logic        rst2 = 1'b0, clr2 = 1'b0, iv2 = 1'b0, or2 = 1'b1;
   logic [11:0] p2 = '0;
   logic        ir2, ov2, ovf2;
   logic [15:0] sum2;

   prod_accum u0 (
      .clk(clk), .rst_n(rst0), .clear(clr0), .in_valid(iv0), .in_ready(ir0),
      .product(p0), .out_valid(ov0), .out_ready(or0), .out_sum(sum0), .out_ovf(ovf0)
   );

   prod_accum #(.WIDTH(6), .ACC_WIDTH(12), .COUNT(2)) u1 (
      .clk(clk), .rst_n(rst1), .clear(clr1), .in_valid(iv1), .in_ready(ir1),
      .product(p1), .out_valid(ov1), .out_ready(or1), .out_sum(sum1), .out_ovf(ovf1)
   );

   prod_accum #(.WIDTH(6), .ACC_WIDTH(16), .COUNT(1)) u2 (
      .clk(clk), .rst_n(rst2), .clear(clr2), .in_valid(iv2), .in_ready(ir2),
      .product(p2), .out_valid(ov2), .out_ready(or2), .out_sum(sum2), .out_ovf(ovf2)
   );

   // Scoreboards hold {ovf, sum}
   logic [16:0] q0[$];
   logic [12:0] q1[$];
   logic [16:0] q2[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted block sum is compared against the next queued expectation.
   always @(negedge clk) begin
      if (rst0 && ov0 && or0) begin
         if (q0.size() == 0) check("u0_unexpected_out", 32'd1, 32'd0);
         else check("u0_block", {15'd0, ovf0, sum0}, {15'd0, q0.pop_front()});
      end
      if (rst1 && ov1 && or1) begin
         if (q1.size() == 0) check("u1_unexpected_out", 32'd1, 32'd0);
         else check("u1_block", {19'd0, ovf1, sum1}, {19'd0, q1.pop_front()});
      end
      if (rst2 && ov2 && or2) begin
         if (q2.size() == 0) check("u2_unexpected_out", 32'd1, 32'd0);
         else check("u2_block", {15'd0, ovf2, sum2}, {15'd0, q2.pop_front()});
      end
   end

   task automatic send0(input logic [11:0] p);
      iv0 = 1'b1; p0 = p;
      @(posedge clk); #1;
      iv0 = 1'b0;
   endtask

   task automatic send1(input logic [11:0] p);
      iv1 = 1'b1; p1 = p;
      @(posedge clk); #1;
      iv1 = 1'b0;
   endtask

   task automatic send2(input logic [11:0] p);
      iv2 = 1'b1; p2 = p;
      @(posedge clk); #1;
      iv2 = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_in_ready",  {31'd0, ir0},  32'd1);
      check("rst_out_valid", {31'd0, ov0},  32'd0);
      check("rst_out_sum",   {16'd0, sum0}, 32'd0);
      check("rst_out_ovf",   {31'd0, ovf0}, 32'd0);
      @(posedge clk); #1;

      // Basic block: 10 - 15 + 20 + 1 = 16
      q0.push_back({1'b0, 16'd16});
      send0(12'd10); send0(12'hFF1); send0(12'd20); send0(12'd1);
      @(negedge clk);
      check("basic_latency_out_valid", {31'd0, ov0}, 32'd1);
      check("basic_hold_in_ready",     {31'd0, ir0}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("basic_release_in_ready", {31'd0, ir0}, 32'd1);
      @(posedge clk); #1;

      // Backpressure: 1+2+3+4 = 10 held for 5 cycles, in_valid ignored while held
      or0 = 1'b0;
      q0.push_back({1'b0, 16'd10});
      send0(12'd1); send0(12'd2); send0(12'd3); send0(12'd4);
      iv0 = 1'b1; p0 = 12'd50;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", {31'd0, ir0},  32'd0);
         check("bp_out_sum",  {16'd0, sum0}, 32'd10);
      end
      @(posedge clk); #1;
      iv0 = 1'b0; or0 = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_release_in_ready", {31'd0, ir0}, 32'd1);
      @(posedge clk); #1;
      q0.push_back({1'b0, 16'd20});
      send0(12'd5); send0(12'd5); send0(12'd5); send0(12'd5);
      repeat (2) @(posedge clk);
      #1;

      // Clear after two 7s, with a product presented in the clear cycle
      send0(12'd7); send0(12'd7);
      clr0 = 1'b1; iv0 = 1'b1; p0 = 12'd100;
      @(posedge clk); #1;
      clr0 = 1'b0; iv0 = 1'b0;
      q0.push_back({1'b0, 16'hFFFC});
      send0(12'hFFF); send0(12'hFFF); send0(12'hFFF); send0(12'hFFF);
      repeat (2) @(posedge clk);
      #1;

      // Reset while holding a sum: held result discarded
      or0 = 1'b0;
      send0(12'd2); send0(12'd2); send0(12'd2); send0(12'd2);
      @(negedge clk);
      check("rsthold_pre_out_valid", {31'd0, ov0},  32'd1);
      check("rsthold_pre_out_sum",   {16'd0, sum0}, 32'd8);
      @(posedge clk); #1;
      rst0 = 1'b0;
      @(posedge clk); #1;
      rst0 = 1'b1;
      @(negedge clk);
      check("rsthold_out_valid", {31'd0, ov0},  32'd0);
      check("rsthold_out_sum",   {16'd0, sum0}, 32'd0);
      check("rsthold_out_ovf",   {31'd0, ovf0}, 32'd0);
      check("rsthold_in_ready",  {31'd0, ir0},  32'd1);
      or0 = 1'b1;
      @(posedge clk); #1;
      q0.push_back({1'b0, 16'd4});
      send0(12'd1); send0(12'd1); send0(12'd1); send0(12'd1);
      repeat (2) @(posedge clk);
      #1;

      // Overflow on a 12-bit accumulator: 1024 + 1024, then min + (-1), then a clean block
`ifdef PROD_ACCUM_SAT_EN
      q1.push_back({1'b1, 12'h7FF});
      q1.push_back({1'b1, 12'h800});
`else
      q1.push_back({1'b1, 12'h800});
      q1.push_back({1'b1, 12'h7FF});
`endif
      q1.push_back({1'b0, 12'h003});
      send1(12'd1024); send1(12'd1024);
      @(negedge clk);
      check("sat_latency_out_valid", {31'd0, ov1}, 32'd1);
      @(posedge clk); #1;
      send1(12'h800); send1(12'hFFF);
      @(posedge clk); #1;
      send1(12'd1); send1(12'd2);
      repeat (2) @(posedge clk);
      #1;

      // COUNT=1: every transfer yields a block
      q2.push_back({1'b0, 16'hFC00});
      send2(12'hC00);
      @(negedge clk);
      check("count1_latency_out_valid", {31'd0, ov2}, 32'd1);
      @(posedge clk); #1;
      q2.push_back({1'b0, 16'd5});
      send2(12'd5);
      repeat (3) @(posedge clk);
      #1;

      check("u0_queue_drained", q0.size(), 32'd0);
      check("u1_queue_drained", q1.size(), 32'd0);
      check("u2_queue_drained", q2.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
